// File: rtl/adc_dual_spi_capture_pkg.sv
// rtl/adc_dual_spi_capture_pkg.sv - shared types and frame geometry for the dual ADC capture
package adc_dual_spi_capture_pkg;

  // Sequencer states, in the order they are visited after a restart.
  typedef enum logic [2:0] {
    START     = 3'd0,
    AMP_SHIFT = 3'd1,
    CONV      = 3'd2,
    ADC_FRAME = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Preamp gain word length and the fall count that ends the gain shift.
  localparam int         AMP_BITS  = 8;
  localparam logic [3:0] AMP_LAST  = 4'd8;

  // CONV phase counter: tick 0 raises CONV, tick 2 drops it (one SCK period high).
  localparam logic [1:0] CONV_LAST = 2'd2;

  // ADC frame: 34 SCK cycles, first bit lands in the MSB.
  localparam int         FRAME_LEN  = 34;
  localparam logic [5:0] FRAME_LAST = 6'd34;

  // Sample width and where each channel sits in the finished frame.
  localparam int SAMPLE_W = 14;
  localparam int CH0_MSB  = 30;
  localparam int CH0_LSB  = 17;
  localparam int CH1_MSB  = 14;
  localparam int CH1_LSB  = 1;

endpackage

// File: rtl/adc_dual_spi_capture_tick_div.sv
// rtl/adc_dual_spi_capture_tick_div.sv - SCK half-period tick generator and free-running divided clock
module spi_tick_div #(
  parameter int HALF_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic clk_out
);

  localparam int             CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;

  // A tick marks the last clk of each SCK half-period.
  assign tick = (cnt == LAST);

  // Wrap counter at HALF_DIV-1 and toggle the divided clock on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (tick) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_dual_spi_capture.sv
// rtl/adc_dual_spi_capture.sv - single-shot SPI master: program preamp gain, convert, capture one dual-channel ADC frame
module adc_dual_spi_capture
  import adc_dual_spi_capture_pkg::*;
#(
  parameter int         HALF_DIV = 25,
  parameter logic [7:0] AMP_GAIN = 8'h11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 spi_miso,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  output logic                 amp_cs,
  output logic                 amp_shdn,
  output logic                 adc_conv,
  output logic                 spi_ss_b,
  output logic                 sf_ce0,
  output logic                 fpga_init_b,
  output logic                 dac_cs,
  output logic                 clk_out,
  output logic                 a1,
  output logic                 a2,
  output logic [FRAME_LEN-1:0] adc_data,
  output logic [SAMPLE_W-1:0]  adc_data1,
  output logic [SAMPLE_W-1:0]  adc_data2
);

  logic                 tick;
  state_t               state;
  state_t               state_next;
  logic [AMP_BITS-1:0]  amp_sr;
  logic [3:0]           amp_cnt;
  logic [1:0]           conv_cnt;
  logic [5:0]           adc_clk_count;
  logic                 miso_meta;
  logic                 miso_sync;
  logic [FRAME_LEN-1:0] frame_next;

  // Other devices on the shared bus stay deselected; the preamp is never shut down.
  assign amp_shdn    = 1'b0;
  assign spi_ss_b    = 1'b1;
  assign sf_ce0      = 1'b1;
  assign fpga_init_b = 1'b1;
  assign dac_cs      = 1'b1;

  // Frame contents after the current falling-edge sample is shifted in.
  assign frame_next = {adc_data[FRAME_LEN-2:0], miso_sync};

  spi_tick_div #(
    .HALF_DIV (HALF_DIV)
  ) u_tick_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .clk_out (clk_out)
  );

  // Bring the ADC data pin into the clk domain; it is sampled half an SCK period after it changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= spi_miso;
      miso_sync <= miso_meta;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: enable forces START immediately; all other moves happen on ticks.
  always_comb begin
    state_next = state;
    if (enable) begin
      state_next = START;
    end else if (tick) begin
      case (state)
        START:     state_next = AMP_SHIFT;
        AMP_SHIFT: if (amp_cnt == AMP_LAST) state_next = CONV;
        CONV:      if (conv_cnt == CONV_LAST) state_next = ADC_FRAME;
        ADC_FRAME: if (spi_sck && (adc_clk_count == FRAME_LAST)) state_next = DONE;
        default:   state_next = state;
      endcase
    end
  end

  // Bus pins, shift registers and counters, all stepped on ticks of the active state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sck       <= 1'b0;
      spi_mosi      <= 1'b0;
      amp_cs        <= 1'b1;
      adc_conv      <= 1'b0;
      a1            <= 1'b0;
      a2            <= 1'b0;
      adc_data      <= '0;
      adc_data1     <= '0;
      adc_data2     <= '0;
      amp_sr        <= '0;
      amp_cnt       <= '0;
      conv_cnt      <= '0;
      adc_clk_count <= '0;
    end else if (enable) begin
      // Park the bus; captured results stay visible until the next start.
      spi_sck  <= 1'b0;
      amp_cs   <= 1'b1;
      adc_conv <= 1'b0;
      spi_mosi <= 1'b0;
    end else if (tick) begin
      case (state)
        START: begin
          // Begin a fresh shot: drop old results and present the gain MSB before the first rise.
          spi_sck   <= 1'b0;
          amp_cs    <= 1'b0;
          a1        <= 1'b0;
          a2        <= 1'b0;
          adc_data  <= '0;
          adc_data1 <= '0;
          adc_data2 <= '0;
          spi_mosi  <= AMP_GAIN[AMP_BITS-1];
          amp_sr    <= {AMP_GAIN[AMP_BITS-2:0], 1'b0};
          amp_cnt   <= '0;
        end
        AMP_SHIFT: begin
          if (amp_cnt == AMP_LAST) begin
            // All gain bits clocked: release the preamp before CONV is raised.
            amp_cs   <= 1'b1;
            a1       <= 1'b1;
            spi_mosi <= 1'b0;
            conv_cnt <= '0;
          end else if (!spi_sck) begin
            spi_sck <= 1'b1;
          end else begin
            // Falling edge: the preamp has taken the bit, move to the next one.
            spi_sck  <= 1'b0;
            amp_cnt  <= amp_cnt + 1'b1;
            spi_mosi <= amp_sr[AMP_BITS-1];
            amp_sr   <= {amp_sr[AMP_BITS-2:0], 1'b0};
          end
        end
        CONV: begin
          if (conv_cnt == CONV_LAST) begin
            adc_conv      <= 1'b0;
            adc_clk_count <= '0;
          end else begin
            adc_conv <= 1'b1;
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        ADC_FRAME: begin
          if (!spi_sck) begin
            spi_sck       <= 1'b1;
            adc_clk_count <= adc_clk_count + 1'b1;
          end else begin
            // Falling edge: sample the ADC, and on the last bit publish both channels.
            spi_sck  <= 1'b0;
            adc_data <= frame_next;
            if (adc_clk_count == FRAME_LAST) begin
              adc_data1 <= frame_next[CH0_MSB:CH0_LSB];
              adc_data2 <= frame_next[CH1_MSB:CH1_LSB];
              a2        <= 1'b1;
            end
          end
        end
        default: begin
          spi_sck  <= 1'b0;
          amp_cs   <= 1'b1;
          adc_conv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dual_spi_capture.sv
// tb/tb_adc_dual_spi_capture.sv - table-driven bench for adc_dual_spi_capture with an ADC serial model
module tb_adc_dual_spi_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        spi_miso = 1'b0;
  logic        spi_sck, spi_mosi, amp_cs, amp_shdn, adc_conv;
  logic        spi_ss_b, sf_ce0, fpga_init_b, dac_cs, clk_out, a1, a2;
  logic [33:0] adc_data;
  logic [13:0] adc_data1, adc_data2;

  adc_dual_spi_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spi_miso    (spi_miso),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .amp_cs      (amp_cs),
    .amp_shdn    (amp_shdn),
    .adc_conv    (adc_conv),
    .spi_ss_b    (spi_ss_b),
    .sf_ce0      (sf_ce0),
    .fpga_init_b (fpga_init_b),
    .dac_cs      (dac_cs),
    .clk_out     (clk_out),
    .a1          (a1),
    .a2          (a2),
    .adc_data    (adc_data),
    .adc_data1   (adc_data1),
    .adc_data2   (adc_data2)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic        dc;
    logic [13:0] exp_d1;
    logic [13:0] exp_d2;
    logic [33:0] exp_frame;
  } vec_t;

  vec_t v [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tie_bad = 0;
  int sck_rises, amp_rises, frame_rises, clkout_toggles;
  int conv_rise_cyc, conv_width;
  logic [7:0]  amp_word;
  logic        cs_at_conv, in_frame, a2_rose, rand_miso;
  logic        p_sck, p_conv, p_a2, p_clkout;
  logic [13:0] cur_ch0, cur_ch1;
  logic        cur_dc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clk cycle, observed on the falling edge: bus monitor plus the ADC serial model.
  task automatic step();
    int old;
    @(negedge clk);
    cyc++;
    if (spi_ss_b !== 1'b1 || sf_ce0 !== 1'b1 || fpga_init_b !== 1'b1 ||
        dac_cs !== 1'b1 || amp_shdn !== 1'b0) tie_bad++;
    if (spi_sck && !p_sck) begin
      sck_rises++;
      if (!amp_cs) begin
        amp_word = {amp_word[6:0], spi_mosi};
        amp_rises++;
      end
      if (in_frame) begin
        frame_rises++;
        old = int'(dut.adc_clk_count) - 1;
        if (old >= 3 && old <= 16)       spi_miso = cur_ch0[16 - old];
        else if (old >= 19 && old <= 32) spi_miso = cur_ch1[32 - old];
        else                             spi_miso = cur_dc;
      end
    end
    if (adc_conv && !p_conv) begin
      conv_rise_cyc = cyc;
      cs_at_conv = amp_cs;
    end
    if (!adc_conv && p_conv) begin
      conv_width = cyc - conv_rise_cyc;
      in_frame = 1'b1;
    end
    if (a2 && !p_a2) a2_rose = 1'b1;
    if (clk_out !== p_clkout) clkout_toggles++;
    if (rand_miso) spi_miso = 1'($urandom_range(0, 1));
    p_sck = spi_sck;
    p_conv = adc_conv;
    p_a2 = a2;
    p_clkout = clk_out;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sck"},     64'(spi_sck),   64'(0));
    chk({tag, "_mosi"},    64'(spi_mosi),  64'(0));
    chk({tag, "_amp_cs"},  64'(amp_cs),    64'(1));
    chk({tag, "_conv"},    64'(adc_conv),  64'(0));
    chk({tag, "_a1"},      64'(a1),        64'(0));
    chk({tag, "_a2"},      64'(a2),        64'(0));
    chk({tag, "_frame"},   64'(adc_data),  64'(0));
    chk({tag, "_data1"},   64'(adc_data1), 64'(0));
    chk({tag, "_data2"},   64'(adc_data2), 64'(0));
    chk({tag, "_clk_out"}, 64'(clk_out),   64'(0));
  endtask

  task automatic run_frame(input int i, input bit hold_chk);
    int n;
    cur_ch0 = v[i].ch0;
    cur_ch1 = v[i].ch1;
    cur_dc  = v[i].dc;
    enable = 1'b1;
    repeat (5) step();
    if (hold_chk) begin
      chk("held_data1_during_enable", 64'(adc_data1), 64'(v[i-1].exp_d1));
      chk("held_a2_during_enable",    64'(a2),        64'(1));
      chk("parked_sck_during_enable", 64'(spi_sck),   64'(0));
    end
    amp_word = 8'h00;
    amp_rises = 0;
    frame_rises = 0;
    conv_width = 0;
    cs_at_conv = 1'b0;
    in_frame = 1'b0;
    a2_rose = 1'b0;
    enable = 1'b0;
    n = 0;
    while (!a2_rose && n < 5950) begin
      step();
      n++;
    end
    chk($sformatf("v%0d_done_within_119us", i), 64'(n < 5950), 64'(1));
    chk($sformatf("v%0d_data1", i), 64'(adc_data1), 64'(v[i].exp_d1));
    chk($sformatf("v%0d_data2", i), 64'(adc_data2), 64'(v[i].exp_d2));
    chk($sformatf("v%0d_frame", i), 64'(adc_data),  64'(v[i].exp_frame));
    chk($sformatf("v%0d_a1", i),    64'(a1),        64'(1));
    chk($sformatf("v%0d_a2", i),    64'(a2),        64'(1));
    chk($sformatf("v%0d_amp_word", i),  64'(amp_word),    64'(8'h11));
    chk($sformatf("v%0d_amp_bits", i),  64'(amp_rises),   64'(8));
    chk($sformatf("v%0d_conv_width", i), 64'(conv_width), 64'(50));
    chk($sformatf("v%0d_cs_high_at_conv", i), 64'(cs_at_conv), 64'(1));
    chk($sformatf("v%0d_frame_sck_rises", i), 64'(frame_rises), 64'(34));
  endtask

  initial begin
    int n;
    v[0] = '{ch0: 14'b00001010001001, ch1: 14'b00001101101001, dc: 1'b0,
             exp_d1: 14'h0289, exp_d2: 14'h0369,
             exp_frame: {3'b000, 14'h0289, 2'b00, 14'h0369, 1'b0}};
    v[1] = '{ch0: 14'h3FFF, ch1: 14'h0000, dc: 1'b1,
             exp_d1: 14'h3FFF, exp_d2: 14'h0000,
             exp_frame: {3'b111, 14'h3FFF, 2'b11, 14'h0000, 1'b1}};
    v[2] = '{ch0: 14'h2AAA, ch1: 14'h1555, dc: 1'b0,
             exp_d1: 14'h2AAA, exp_d2: 14'h1555,
             exp_frame: {3'b000, 14'h2AAA, 2'b00, 14'h1555, 1'b0}};
    v[3] = '{ch0: 14'h0001, ch1: 14'h2000, dc: 1'b1,
             exp_d1: 14'h0001, exp_d2: 14'h2000,
             exp_frame: {3'b111, 14'h0001, 2'b11, 14'h2000, 1'b1}};

    sck_rises = 0; amp_rises = 0; frame_rises = 0; clkout_toggles = 0;
    conv_rise_cyc = 0; conv_width = 0; amp_word = 8'h00;
    cs_at_conv = 1'b0; in_frame = 1'b0; a2_rose = 1'b0; rand_miso = 1'b0;
    p_sck = 1'b0; p_conv = 1'b0; p_a2 = 1'b0; p_clkout = 1'b0;
    cur_ch0 = '0; cur_ch1 = '0; cur_dc = 1'b0;

    repeat (4) step();
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;

    run_frame(0, 1'b0);

    // DONE must hold everything while the data pin toggles.
    rand_miso = 1'b1;
    sck_rises = 0;
    clkout_toggles = 0;
    repeat (10000) step();
    rand_miso = 1'b0;
    chk("hold_sck_rises",      64'(sck_rises),      64'(0));
    chk("hold_clk_out_toggles", 64'(clkout_toggles), 64'(400));
    chk("hold_data1",          64'(adc_data1),      64'(v[0].exp_d1));
    chk("hold_data2",          64'(adc_data2),      64'(v[0].exp_d2));
    chk("hold_frame",          64'(adc_data),       64'(v[0].exp_frame));
    chk("hold_a2",             64'(a2),             64'(1));

    run_frame(1, 1'b1);
    run_frame(2, 1'b1);

    // Reset in the middle of a frame discards it at once.
    cur_ch0 = v[3].ch0;
    cur_ch1 = v[3].ch1;
    cur_dc  = v[3].dc;
    enable = 1'b1;
    repeat (5) step();
    in_frame = 1'b0;
    enable = 1'b0;
    n = 0;
    while (!(in_frame && dut.adc_clk_count == 6'd10) && n < 4000) begin
      step();
      n++;
    end
    chk("midframe_reached_count10", 64'(n < 4000), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_values("midframe_reset");
    repeat (3) step();
    in_frame = 1'b0;
    enable = 1'b1;
    rst_n = 1'b1;

    run_frame(3, 1'b0);

    chk("tied_pins", 64'(tie_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
